nz_result_writer: RTL and testbench



---
 rtl/nz_result_writer_pkg.sv | 22 ++
 rtl/nz_result_writer_if.sv | 33 +++
 rtl/nz_result_writer_fifo.sv | 68 ++++++
 rtl/nz_result_writer.sv | 129 ++++++++++++
 tb/tb_nz_result_writer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nz_result_writer_pkg.sv
// Shared definitions for the nonzero-result writer and its upstream detector.
// Holds the run-state encoding, the result width and the two signed-zero encodings.
package nz_result_writer_pkg;

    localparam int NZ_DATA_W = 48;

    localparam logic [NZ_DATA_W-1:0] POS_ZERO = 48'h000000000000;
    localparam logic [NZ_DATA_W-1:0] NEG_ZERO = 48'h800000000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of lanes carrying a word this cycle (0, 1 or 2).
    function automatic logic [1:0] lane_count(input logic we_a, input logic we_b);
        return {1'b0, we_a} + {1'b0, we_b};
    endfunction

endpackage

// File: rtl/nz_result_writer_if.sv
// Result-pair input stream and result-memory write port of the writer.
// master = the writer itself; slave = the detector/memory environment around it.
interface nz_result_writer_if
    import nz_result_writer_pkg::*;
#(
    parameter int DATA_W = NZ_DATA_W,
    parameter int ADDR_W = 10
) ();

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              we0;
    logic              we1;

    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;

    modport master (
        input  in_valid, in_last, data0, data1, we0, we1, mem_ready,
        output in_ready, mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_last, data0, data1, we0, we1, mem_ready,
        input  in_ready, mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/nz_result_writer_fifo.sv
// Synchronous FIFO accepting 0, 1 or 2 words per cycle and releasing at most one.
// Pointers carry an extra wrap bit so full and empty are told apart by the MSB.
module nz_sync_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 8,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        push_cnt,
    input  logic [DATA_W-1:0] push_d0,
    input  logic [DATA_W-1:0] push_d1,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [PTR_W-1:0]  count
);

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_nxt1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              pop_ok;

    assign wptr_nxt1 = wptr_q + PTR_W'(1);
    assign pop_ok    = pop & ~empty;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    assign count = wptr_q - rptr_q;
    assign head  = mem_q[rptr_q[IDX_W-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_cnt != 2'd0) begin
            mem_d[wptr_q[IDX_W-1:0]] = push_d0;
        end
        if (push_cnt == 2'd2) begin
            mem_d[wptr_nxt1[IDX_W-1:0]] = push_d1;
        end
        wptr_d = wptr_q + PTR_W'(push_cnt);
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/nz_result_writer.sv
// Compacts enabled result lanes into a FIFO and streams them to result memory
// at consecutive addresses, framing each run with start/last and a done pulse.
module nz_result_writer
    import nz_result_writer_pkg::*;
#(
    parameter int DATA_W = NZ_DATA_W,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    nz_result_writer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   write_count
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PTR_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  fifo_free;
    logic [1:0]        push_cnt;
    logic [DATA_W-1:0] push_d0;
    logic              accept;
    logic              pop;
    logic              in_ready_int;
    logic              wr_en_int;

    assign fifo_free = PTR_W'(DEPTH) - fifo_count;
    assign accept    = bus.in_valid & in_ready_int;
    assign push_cnt  = accept ? lane_count(bus.we0, bus.we1) : 2'd0;
    // Lane 1 slides into the first slot when lane 0 carries nothing.
    assign push_d0   = bus.we0 ? bus.data0 : bus.data1;
    assign pop       = wr_en_int & bus.mem_ready;

    nz_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_cnt (push_cnt),
        .push_d0  (push_d0),
        .push_d1  (bus.data1),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && bus.in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // in_ready looks only at registered occupancy, never at mem_ready.
    always_comb begin
        in_ready_int = 1'b0;
        wr_en_int    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state_q)
            ST_IDLE:  busy = 1'b0;
            ST_RUN: begin
                in_ready_int = ~fifo_full && (fifo_free >= PTR_W'(2));
                wr_en_int    = ~fifo_empty;
            end
            ST_DRAIN: wr_en_int = ~fifo_empty;
            ST_DONE:  done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        wcnt_d = wcnt_q;
        if (state_q == ST_IDLE && start) begin
            addr_d = base_addr;
            wcnt_d = '0;
        end else if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            if (wcnt_q != {CNT_W{1'b1}}) begin
                wcnt_d = wcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            wcnt_q <= '0;
        end else begin
            addr_q <= addr_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.mem_wr_en = wr_en_int;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = fifo_head;
    assign write_count   = wcnt_q;

endmodule

// File: tb/tb_nz_result_writer.sv
// Scoreboard bench for nz_result_writer: accepted pairs feed an address/data
// queue model; a monitor pops it on every memory write handshake.
module tb_nz_result_writer;
    import nz_result_writer_pkg::*;

    localparam int DATA_W = 48;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  write_count;

    nz_result_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    nz_result_writer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] exp_a_q[$];
    logic [DATA_W-1:0] exp_d_q[$];
    int model_addr = 0;
    int model_cnt  = 0;

    int   rdy_mode  = 0;
    logic rdy_fixed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: every enabled lane, lane 0 first, lands at the next address mod 2^ADDR_W.
    task automatic model_push(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                              input logic w0, input logic w1);
        if (w0) begin
            exp_a_q.push_back(ADDR_W'(model_addr));
            exp_d_q.push_back(d0);
            model_addr = (model_addr + 1) % (1 << ADDR_W);
            model_cnt++;
        end
        if (w1) begin
            exp_a_q.push_back(ADDR_W'(model_addr));
            exp_d_q.push_back(d1);
            model_addr = (model_addr + 1) % (1 << ADDR_W);
            model_cnt++;
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.mem_ready = (rdy_mode != 0) ? ($urandom_range(0, 1) == 1) : rdy_fixed;
    end

    logic              held_v = 1'b0;
    logic [ADDR_W-1:0] h_a;
    logic [DATA_W-1:0] h_d;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_hold", 64'({bus.mem_wr_en, bus.mem_addr, bus.mem_wdata}),
                      64'({1'b1, h_a, h_d}));
            end
            if (bus.mem_wr_en) begin
                if (bus.mem_ready) begin
                    held_v = 1'b0;
                    if (exp_a_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                                 bus.mem_addr, bus.mem_wdata);
                    end else begin
                        ea = exp_a_q.pop_front();
                        ed = exp_d_q.pop_front();
                        check("wr_addr", 64'(bus.mem_addr), 64'(ea));
                        check("wr_data", 64'(bus.mem_wdata), 64'(ed));
                    end
                end else begin
                    held_v = 1'b1;
                    h_a    = bus.mem_addr;
                    h_d    = bus.mem_wdata;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic start_run(input logic [ADDR_W-1:0] base);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        if (i == 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy stuck at %0b, required 0", busy);
        end
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = base;
        model_addr = int'(base);
        model_cnt  = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic send_pair(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                             input logic w0, input logic w1, input logic last,
                             output int waited);
        bus.in_valid = 1'b1;
        bus.data0    = d0;
        bus.data1    = d1;
        bus.we0      = w0;
        bus.we1      = w1;
        bus.in_last  = last;
        waited = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                model_push(d0, d1, w0, w1);
                waited = i;
                break;
            end
        end
        if (waited < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b, required 1 within 200 cycles", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        if (i == 300) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: done=%0b, required a pulse", name, done);
        end else begin
            check({name, "_write_count"}, 64'(write_count), 64'((model_cnt > 65535) ? 65535 : model_cnt));
            check({name, "_pending"}, 64'(exp_a_q.size()), 64'(0));
            @(negedge clk);
            check({name, "_done_one_cycle"}, 64'(done), 64'(0));
            check({name, "_idle"}, 64'(busy), 64'(0));
            check({name, "_count_hold"}, 64'(write_count), 64'(model_cnt));
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        w = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: w = POS_ZERO;
            1: w = NEG_ZERO;
            default: ;
        endcase
        return w;
    endfunction

    int waited;
    int accepts;
    int npairs;
    logic [DATA_W-1:0] rd0, rd1;
    logic rw0, rw1;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.data0     = '0;
        bus.data1     = '0;
        bus.we0       = 1'b0;
        bus.we1       = 1'b0;
        bus.mem_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_mem_wr_en", 64'(bus.mem_wr_en), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_write_count", 64'(write_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed run, memory always ready.
        rdy_mode = 0; rdy_fixed = 1'b1;
        start_run(10'h010);
        send_pair(48'hA0A0_0000_000A, 48'hB0B0_0000_000B, 1'b1, 1'b1, 1'b0, waited);
        send_pair(48'hC0C0_0000_000C, 48'hD0D0_0000_000D, 1'b0, 1'b1, 1'b0, waited);
        send_pair(48'hE0E0_0000_000E, 48'hF0F0_0000_000F, 1'b1, 1'b0, 1'b1, waited);
        finish_run("directed");

        // Signed zeros with enables low write nothing.
        start_run(10'h040);
        for (int i = 0; i < 5; i++) send_pair(POS_ZERO, NEG_ZERO, 1'b0, 1'b0, 1'b0, waited);
        send_pair(NEG_ZERO, POS_ZERO, 1'b0, 1'b0, 1'b1, waited);
        finish_run("zeros");

        // Backpressure: only four double pairs fit in eight entries.
        rdy_fixed = 1'b0;
        start_run(10'h100);
        accepts = 0;
        bus.in_valid = 1'b1; bus.we0 = 1'b1; bus.we1 = 1'b1; bus.in_last = 1'b0;
        bus.data0 = {$urandom(), $urandom()}; bus.data1 = {$urandom(), $urandom()};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                model_push(bus.data0, bus.data1, 1'b1, 1'b1);
                accepts++;
            end
            @(posedge clk);
            #1;
            bus.data0 = {$urandom(), $urandom()};
            bus.data1 = {$urandom(), $urandom()};
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepts", 64'(accepts), 64'(4));
        check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        check("bp_wr_pending", 64'(bus.mem_wr_en), 64'(1));
        rdy_fixed = 1'b1;
        send_pair(POS_ZERO, POS_ZERO, 1'b0, 1'b0, 1'b1, waited);
        finish_run("backpressure");

        // Address wrap past the top of memory.
        rdy_mode = 1;
        start_run(10'h3FE);
        send_pair(48'h0000_1111_0001, 48'h0, 1'b1, 1'b0, 1'b0, waited);
        send_pair(48'h0, 48'h0000_2222_0002, 1'b0, 1'b1, 1'b0, waited);
        send_pair(48'h8000_3333_0003, 48'h0, 1'b1, 1'b0, 1'b1, waited);
        finish_run("wrap");
        check("wrap_next_addr", 64'(bus.mem_addr), 64'(10'h001));

        // One word in, one word out, every cycle.
        rdy_mode = 0; rdy_fixed = 1'b1;
        start_run(10'h020);
        for (int i = 0; i < 12; i++) begin
            send_pair({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b0,
                      (i == 11), waited);
            check("thru_no_stall", 64'(waited), 64'(0));
        end
        finish_run("throughput");

        // Reset with words queued discards them.
        rdy_fixed = 1'b0;
        start_run(10'h050);
        for (int i = 0; i < 3; i++)
            send_pair({$urandom(), $urandom()}, 48'h0, 1'b1, 1'b0, 1'b0, waited);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", 64'(bus.mem_wr_en), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_write_count", 64'(write_count), 64'(0));
        check("mid_rst_addr", 64'(bus.mem_addr), 64'(0));
        exp_a_q.delete();
        exp_d_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_fixed = 1'b1;
        start_run(10'h060);
        send_pair(48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1'b1, 1'b1, 1'b0, waited);
        send_pair(48'h0, 48'h7777_0000_7777, 1'b0, 1'b1, 1'b1, waited);
        finish_run("after_reset");

        // Random runs with random memory backpressure.
        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            start_run(ADDR_W'($urandom()));
            npairs = $urandom_range(1, 10);
            for (int i = 0; i < npairs; i++) begin
                rd0 = rand_word();
                rd1 = rand_word();
                rw0 = (rd0 != POS_ZERO) && (rd0 != NEG_ZERO);
                rw1 = (rd1 != POS_ZERO) && (rd1 != NEG_ZERO);
                send_pair(rd0, rd1, rw0, rw1, (i == npairs - 1), waited);
            end
            finish_run("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
